// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decoded control and operands into EX,
// inserts load-use bubbles, applies flushes and counts stall cycles.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [10:0]           id_ctrl,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [5:0]            id_funct,
    input  logic                  ex_flush,
    input  logic                  ex_hold,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [10:0]           ex_ctrl,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [5:0]            ex_funct,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int unsigned CTRL_W       = 11;
    localparam int unsigned BIT_BRANCH   = 8;
    localparam int unsigned BIT_MEMREAD  = 7;
    localparam int unsigned BIT_MEMWRITE = 5;
    localparam int unsigned BIT_ALUSRC   = 4;

    logic use_rt;
    logic load_use;
    logic cnt_sat;

    // Load-use hazard: a load in EX whose destination feeds the ID instruction.
    always_comb begin
        use_rt   = ~id_ctrl[BIT_ALUSRC] | id_ctrl[BIT_MEMWRITE] | id_ctrl[BIT_BRANCH];
        load_use = id_valid & ex_valid & ex_ctrl[BIT_MEMREAD]
                 & (ex_rt != REG_ADDR_W'(0))
                 & ((ex_rt == id_rs) | (use_rt & (ex_rt == id_rt)));
        stall    = load_use & ~ex_flush;
        cnt_sat  = &stall_count;
    end

    // Priority: flush, hold, load-use bubble, normal advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_W'(0);
            ex_pc4      <= DATA_W'(0);
            ex_rs_data  <= DATA_W'(0);
            ex_rt_data  <= DATA_W'(0);
            ex_imm      <= DATA_W'(0);
            ex_rs       <= REG_ADDR_W'(0);
            ex_rt       <= REG_ADDR_W'(0);
            ex_rd       <= REG_ADDR_W'(0);
            ex_funct    <= 6'(0);
            stall_count <= CNT_W'(0);
        end else if (ex_flush || !ex_hold) begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_funct   <= id_funct;
            if (ex_flush || stall) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_W'(0);
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : CTRL_W'(0);
            end
            if (!ex_flush && stall && !cnt_sat)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed hazard/flush/hold cases plus
// randomized traffic against a field-level reference model.
module tb_id_ex_pipe_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic          valid;
        logic [10:0]   ctrl;
        logic [DW-1:0] pc4, rsd, rtd, imm;
        logic [AW-1:0] rs, rt, rd;
        logic [5:0]    funct;
        int            cnt;
    } ex_t;

    typedef struct {
        ex_t  cur;
        logic stall;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [10:0]   id_ctrl = '0;
    logic [DW-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic [5:0]    id_funct = '0;
    logic          ex_flush = 1'b0, ex_hold = 1'b0;
    logic          stall, ex_valid;
    logic [10:0]   ex_ctrl;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;
    logic [CW-1:0] stall_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ex_t  model;
    rec_t sb[$];

    id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Control words: {RegDst,Jump,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,BEQFlag,ALUOp}
    localparam logic [10:0] C_ADD  = 11'b1_0_0_0_0_0_0_1_0_10;
    localparam logic [10:0] C_LW   = 11'b0_0_0_1_1_0_1_1_0_00;
    localparam logic [10:0] C_ADDI = 11'b0_0_0_0_0_0_1_1_0_00;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    function automatic ex_t zero_state();
        ex_t z;
        z.valid = 1'b0; z.ctrl = '0; z.pc4 = '0; z.rsd = '0; z.rtd = '0; z.imm = '0;
        z.rs = '0; z.rt = '0; z.rd = '0; z.funct = '0; z.cnt = 0;
        return z;
    endfunction

    // Reference: hazard when a load in EX writes a nonzero register the ID instruction reads.
    function automatic logic model_stall(input ex_t m);
        logic reads_rt;
        logic is_load;
        if (ex_flush) return 1'b0;
        reads_rt = !id_ctrl[4] || id_ctrl[5] || id_ctrl[8];
        is_load  = m.valid && id_valid && m.ctrl[7] && (m.rt != 0);
        return is_load && (m.rt == id_rs || (reads_rt && m.rt == id_rt));
    endfunction

    task automatic drive(input logic v, input logic [10:0] c, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic fl, input logic ho);
        rec_t r;
        ex_t  nx;
        @(negedge clk);
        rst_n      = 1'b1;
        id_valid   = v;       id_ctrl  = c;
        id_rs      = rs;      id_rt    = rt;   id_rd = rd;
        id_pc4     = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm     = $urandom; id_funct = 6'($urandom);
        ex_flush   = fl;      ex_hold  = ho;
        #1;
        r.cur   = model;
        r.stall = model_stall(model);
        sb.push_back(r);
        nx = model;
        if (fl || !ho) begin
            nx.pc4 = id_pc4; nx.rsd = id_rs_data; nx.rtd = id_rt_data; nx.imm = id_imm;
            nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd; nx.funct = id_funct;
            if (fl || r.stall) begin
                nx.valid = 1'b0;
                nx.ctrl  = '0;
                if (!fl) nx.cnt = (model.cnt == CNT_MAX) ? CNT_MAX : model.cnt + 1;
            end else begin
                nx.valid = v;
                nx.ctrl  = v ? c : 11'b0;
            end
        end
        model = nx;
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 128'(ex_valid), 128'(0));
        check({name, "_ctrl"},  128'(ex_ctrl), 128'(0));
        check({name, "_data"},  {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, 128'(0));
        check({name, "_regs"},  128'({ex_rs, ex_rt, ex_rd, ex_funct}), 128'(0));
        check({name, "_count"}, 128'(stall_count), 128'(0));
    endtask

    // Monitor: compares DUT state and stall against the record for this cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                cyc++;
                check("stall", 128'(stall), 128'(r.stall));
                check("ex_valid", 128'(ex_valid), 128'(r.cur.valid));
                check("ex_ctrl", 128'(ex_ctrl), 128'(r.cur.ctrl));
                check("ex_data", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm},
                      {r.cur.pc4, r.cur.rsd, r.cur.rtd, r.cur.imm});
                check("ex_regs", 128'({ex_rs, ex_rt, ex_rd, ex_funct}),
                      128'({r.cur.rs, r.cur.rt, r.cur.rd, r.cur.funct}));
                check("stall_count", 128'(stall_count), 128'(r.cur.cnt));
            end
        end
    end

    initial begin
        logic [10:0] c;
        int          guard;
        model = zero_state();
        #3 check_zero("reset_init");

        // Pass-through R-type, then load-use with stall and recovery.
        drive(1, C_ADD, 5'd1, 5'd2, 5'd3, 0, 0);
        drive(1, C_LW,  5'd4, 5'd2, 5'd0, 0, 0);
        drive(1, C_ADD, 5'd2, 5'd6, 5'd7, 0, 0);
        drive(1, C_ADD, 5'd2, 5'd6, 5'd7, 0, 0);
        // No false stall: lw $0, and addi not reading rt.
        drive(1, C_LW,  5'd4, 5'd0, 5'd0, 0, 0);
        drive(1, C_ADD, 5'd0, 5'd0, 5'd1, 0, 0);
        drive(1, C_LW,  5'd4, 5'd2, 5'd0, 0, 0);
        drive(1, C_ADDI, 5'd5, 5'd2, 5'd0, 0, 0);
        // Flush dominates a pending stall and a hold.
        drive(1, C_LW,  5'd4, 5'd2, 5'd0, 0, 0);
        drive(1, C_ADD, 5'd2, 5'd2, 5'd9, 1, 1);
        // Hold for three cycles with a pending stall, then release.
        drive(1, C_LW,  5'd4, 5'd3, 5'd0, 0, 0);
        repeat (3) drive(1, C_ADD, 5'd3, 5'd1, 5'd8, 0, 1);
        drive(1, C_ADD, 5'd3, 5'd1, 5'd8, 0, 0);
        // Five load-use stalls drive the 2-bit counter into saturation.
        repeat (5) begin
            drive(1, C_LW,  5'd1, 5'd4, 5'd0, 0, 0);
            drive(1, C_ADD, 5'd4, 5'd1, 5'd2, 0, 0);
            drive(1, C_ADD, 5'd4, 5'd1, 5'd2, 0, 0);
        end

        // Asynchronous reset in the high phase with live state.
        drive(1, C_ADD, 5'd1, 5'd2, 5'd3, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        model = zero_state();

        // Randomized traffic with a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            c = 11'($urandom);
            if ($urandom_range(0, 1) == 0) c[7] = 1'b1;
            drive($urandom_range(0, 9) != 0, c,
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #5;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
